alu_mul_seq32: RTL and testbench
================================

# alu_mul_seq32

Iterative 32×32 signed multiplier for the Simple RISC ALU. It is the multiply counterpart to the combinational non-restoring divider and is used by the execute stage for MUL/MULH. It takes one Booth (radix-2) step per clock, with a fixed 32-cycle iteration. A start/busy/done handshake lets the pipeline stall while the multiply is in flight.

## Interface
- `WIDTH`, default 32: operand width. Product width is 2·WIDTH. Only 32 is verified.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply; sampled only in IDLE.
- `multiplicand` input 32: signed operand M; captured when start is accepted.
- `multiplier` input 32: signed operand Q; captured when start is accepted.
- `busy` output 1: high while an operation is in progress (RUN state).
- `done` output 1: single-cycle pulse when the product is valid.
- `product_hi` output 32: upper 32 bits of the signed 64-bit product.
- `product_lo` output 32: lower 32 bits of the signed 64-bit product.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE, start=1:**
  - Capture M into a 33-bit sign-extended register.
  - Load accumulator A=0 (33 bits), Q=multiplier, and Booth bit q_1=0.
  - Set count=0 and go to RUN.
- **IDLE, start=0:** stay in IDLE.
- **RUN, each cycle:**
  - Examine {Q[0], q_1}: 01 gives A=A+M; 10 gives A=A−M; 00 and 11 leave A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right by 1.
  - Increment count.
  - After the step where count==31 completes, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **Result:** `{product_hi, product_lo}` = {A[31:0], Q} after the last step.
  - The result is registered when entering DONE.
  - It holds unchanged until the next accepted start completes.
- **Accumulator width:** 33 bits, so that M=−2^31 (negation overflows 32 bits) gives exact results.
- **Arithmetic:** fully signed two's complement. The 64-bit result is always exact; no overflow flag.
- **start outside IDLE:** ignored and not queued. Operands on the inputs may change freely after acceptance.
- **Zero operands:** no early termination; latency is fixed.

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, count=0, A=0, Q=0.
- **Start accepted on edge N** (IDLE, start=1):
  - busy=1 from edge N through edge N+31.
  - busy=0 and done=1 after edge N+32, with product valid in the same cycle.
  - done=0 after edge N+33.
  - Total latency from start to done is 33 cycles.
- **Back-to-back:** the earliest next start is accepted on edge N+34 (IDLE again). This gives a throughput of one multiply per 34 cycles.
- **Reset mid-RUN or in DONE:** the next edge forces all reset values. No done pulse is issued, and the previous product is cleared.
- **rst and start together:** rst wins; the operation is not accepted.
- **Output mutual exclusion:** busy and done are never high in the same cycle.

## Structure
- **Shared package `alu_pkg`:**
  - `XLEN`=32.
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Iteration count constant `MUL_STEPS`=32.
- **Sub-module `booth_step33`:** combinational.
  - Inputs: A[32:0], Q[31:0], q_1, M[32:0].
  - Outputs: the next shifted {A,Q,q_1}.
- **Top level:** holds the FSM, counter, operand registers and result registers.

## Test plan
- **Basic positive:** M=10, Q=2, start pulse → done after exactly 33 cycles; hi=0x00000000, lo=0x00000014; busy high for cycles 1–32.
- **Mixed sign:** M=7, Q=−3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21). Also check M=−10, Q=3 → lo=0xFFFFFFE2, hi=0xFFFFFFFF.
- **Extremes:**
  - M=−2^31, Q=−2^31 → hi=0x40000000, lo=0x00000000.
  - M=−2^31, Q=−1 → hi=0x00000000, lo=0x80000000.
  - M=0x7FFFFFFF, Q=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- **Handshake:**
  - start re-asserted during RUN with different operands → ignored; the original product is returned.
  - start held high continuously → a new op is accepted every 34 cycles.
  - Product is stable between done pulses.
- **Reset mid-op:** assert rst at RUN cycle 15 → outputs zero on the next edge; no done pulse; a subsequent op completes correctly.
- **Randomized:** 1000 random signed pairs compared against a 64-bit `$signed` multiply reference. Any mismatch is reported and fails the test.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, multiplier FSM encoding, iteration count.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/booth_step33.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the concatenated {A,Q,q_1} register.
module booth_step33 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
  end

  // A is one bit wider than the operands, so the sign survives the M = -2^(W-1) case.
  assign a_nxt   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt   = {sum[0], q[WIDTH-1:1]};
  assign q_1_nxt = q[0];

endmodule

// File: rtl/alu_mul_seq32.sv
// Iterative signed multiplier: one Booth step per clock, fixed MUL_STEPS
// iterations, start/busy/done handshake for execute-stage stalls.
module alu_mul_seq32
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  localparam int CW = $clog2(MUL_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   a, m;
  logic [WIDTH-1:0] q;
  logic             q_1;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_1_nxt;

  booth_step33 #(.WIDTH(WIDTH)) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      a          <= '0;
      q          <= '0;
      q_1        <= 1'b0;
      m          <= '0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= {multiplicand[WIDTH-1], multiplicand};
            a     <= '0;
            q     <= multiplier;
            q_1   <= 1'b0;
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a     <= a_nxt;
          q     <= q_nxt;
          q_1   <= q_1_nxt;
          count <= count + 1'b1;
          // Result is taken straight from the final step so it is valid with done.
          if (count == LAST_STEP) begin
            product_hi <= a_nxt[WIDTH-1:0];
            product_lo <= q_nxt;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  a_busy_done_excl: assert property (@(posedge clk) !(busy && done));

endmodule

// File: tb/tb_alu_mul_seq32.sv
// Self-checking bench for alu_mul_seq32: directed handshake/boundary scenarios
// plus randomized operands against a 64-bit signed multiply reference.
module tb_alu_mul_seq32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done;
  logic [31:0] product_hi, product_lo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  alu_mul_seq32 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return 64'(p);
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the DUT idle. Returns product sampled with done,
  // edges from accept to done (-1 on timeout), busy cycles, and done one cycle later.
  task automatic run_mul(input logic [31:0] mm, input logic [31:0] qq,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output int busy_cyc, output logic done_after);
    int k;
    multiplicand = mm;
    multiplier   = qq;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    k = 0;
    busy_cyc = 0;
    while (!done && k < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      k++;
    end
    lat = done ? k : -1;
    hi  = product_hi;
    lo  = product_lo;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, product_hi, product_lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, expected all zero",
               busy, done, product_hi, product_lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] hi, lo;
    int lat, bc;
    logic da;
    run_mul(32'd10, 32'd2, hi, lo, lat, bc, da);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges after accept, expected 32", lat);
    end
    checks++;
    if (bc !== 32) begin
      errors++;
      $display("FAIL basic_busy: busy for %0d cycles, expected 32", bc);
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0014) begin
      errors++;
      $display("FAIL basic_product: got %h_%h, expected 00000000_00000014", hi, lo);
    end
    checks++;
    if (da !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b one cycle later, expected 0 0", da, busy);
    end
  endtask

  task automatic test_signed_extremes();
    logic [31:0] tm [5] = '{32'd7, 32'hFFFF_FFF6, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tq [5] = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [63:0] te [5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFE2,
                            64'h4000_0000_0000_0000, 64'h0000_0000_8000_0000,
                            64'h3FFF_FFFF_0000_0001};
    logic [31:0] hi, lo;
    int lat, bc;
    logic da;
    for (int i = 0; i < 5; i++) begin
      run_mul(tm[i], tq[i], hi, lo, lat, bc, da);
      checks++;
      if (lat !== 32 || {hi, lo} !== te[i]) begin
        errors++;
        $display("FAIL signed_case%0d: M=%h Q=%h got %h_%h lat=%0d, expected %h lat=32",
                 i, tm[i], tq[i], hi, lo, lat, te[i]);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [31:0] ma, qa;
    int k;
    ma = 32'h1234_5678;
    qa = 32'hFEDC_BA98;
    multiplicand = ma;
    multiplier   = qa;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    multiplicand = 32'h0BAD_F00D;
    multiplier   = 32'h0000_0003;
    k = 0;
    while (!done && k < 40) begin
      if (k == 30) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checks++;
    if (!done || {product_hi, product_lo} !== ref_mul(ma, qa)) begin
      errors++;
      $display("FAIL start_ignored: done=%b got %h_%h, expected %h", done,
               product_hi, product_lo, ref_mul(ma, qa));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int stable_bad;
    logic [63:0] held, exp;
    logic        have;
    multiplicand = 32'hFFFF_FF00;
    multiplier   = 32'h0000_1001;
    exp = ref_mul(32'hFFFF_FF00, 32'h0000_1001);
    start = 1'b1;
    stable_bad = 0;
    have = 1'b0;
    held = '0;
    for (int t = 0; t < 200 && pulses.size() < 3; t++) begin
      @(negedge clk);
      if (done) begin
        pulses.push_back(cyc);
        held = {product_hi, product_lo};
        have = 1'b1;
      end else if (have && {product_hi, product_lo} !== held) begin
        stable_bad++;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses.size() !== 3) begin
      errors++;
      $display("FAIL back_to_back_count: saw %0d done pulses, expected 3", pulses.size());
    end else begin
      checks++;
      if (pulses[1] - pulses[0] !== 34 || pulses[2] - pulses[1] !== 34) begin
        errors++;
        $display("FAIL back_to_back_period: intervals %0d %0d, expected 34 34",
                 pulses[1] - pulses[0], pulses[2] - pulses[1]);
      end
    end
    checks++;
    if (held !== exp) begin
      errors++;
      $display("FAIL back_to_back_product: got %h, expected %h", held, exp);
    end
    checks++;
    if (stable_bad !== 0) begin
      errors++;
      $display("FAIL product_stable: %0d cycles changed between pulses, expected 0", stable_bad);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] hi, lo;
    int lat, bc, seen;
    logic da;
    multiplicand = 32'd1000;
    multiplier   = 32'd1000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, product_hi, product_lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, expected all zero",
               busy, done, product_hi, product_lo);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d done cycles after reset, expected 0", seen);
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_beats_start: busy=%b, expected 0", busy);
    end
    run_mul(32'hFFFF_FFFB, 32'd9, hi, lo, lat, bc, da);
    checks++;
    if (lat !== 32 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFD3) begin
      errors++;
      $display("FAIL after_reset_op: got %h_%h lat=%0d, expected ffffffff_ffffffd3 lat=32",
               hi, lo, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, hi, lo;
    int lat, bc;
    logic da;
    for (int i = 0; i < 1000; i++) begin
      x = rnd_op();
      y = rnd_op();
      run_mul(x, y, hi, lo, lat, bc, da);
      checks++;
      if (lat !== 32 || {hi, lo} !== ref_mul(x, y)) begin
        errors++;
        $display("FAIL random%0d: M=%h Q=%h got %h_%h lat=%0d, expected %h lat=32",
                 i, x, y, hi, lo, lat, ref_mul(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_extremes();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
